// File: rtl/constraint_scheduler_if.sv
// Host and engine signals of the constraint scheduler, bundled with
// modports for the scheduler side (slave) and the host/engine side (master).
interface constraint_scheduler_if #(
  parameter int ADDR_W = 3
);
  logic              start;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_x;
  logic [31:0]       wr_y;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_x;
  logic [31:0]       rd_y;
  logic [31:0]       eng_up_x;
  logic [31:0]       eng_up_y;
  logic [31:0]       eng_x;
  logic [31:0]       eng_y;
  logic [31:0]       eng_down_x;
  logic [31:0]       eng_down_y;
  logic              eng_is_last;
  logic [31:0]       eng_x_res;
  logic [31:0]       eng_y_res;

  modport slave (
    input  start, wr_en, wr_addr, wr_x, wr_y, rd_addr, eng_x_res, eng_y_res,
    output busy, done, rd_x, rd_y,
           eng_up_x, eng_up_y, eng_x, eng_y, eng_down_x, eng_down_y, eng_is_last
  );

  modport master (
    output start, wr_en, wr_addr, wr_x, wr_y, rd_addr, eng_x_res, eng_y_res,
    input  busy, done, rd_x, rd_y,
           eng_up_x, eng_up_y, eng_x, eng_y, eng_down_x, eng_down_y, eng_is_last
  );
endinterface

// File: rtl/constraint_scheduler.sv
// Gauss-Seidel sequencer: feeds one shared combinational constraint engine
// with neighbour triples from a position file and writes results back in place.
module constraint_scheduler #(
  parameter int N_POINTS   = 8,
  parameter int ITERATIONS = 4,
  parameter int ADDR_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  constraint_scheduler_if.slave  bus
);

  localparam int ITER_W = (ITERATIONS < 2) ? 1 : $clog2(ITERATIONS);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_POINTS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic [31:0] pos_x_q [N_POINTS];
  logic [31:0] pos_y_q [N_POINTS];

  logic [31:0] eng_up_x_q, eng_up_y_q, eng_x_q, eng_y_q;
  logic [31:0] eng_down_x_q, eng_down_y_q;
  logic        eng_is_last_q;

  logic              host_wr;
  logic              issue_en;
  logic              wb_en;
  logic              idx_is_last;
  logic [ADDR_W-1:0] up_idx;
  logic [ADDR_W-1:0] down_idx;
  logic              wr_in_range;
  logic              rd_in_range;

  assign idx_is_last = (idx_q == LAST_IDX);
  assign up_idx      = idx_q - FIRST_IDX;
  // The last point has no downstream neighbour; the engine gets itself instead.
  assign down_idx    = idx_is_last ? idx_q : idx_q + FIRST_IDX;
  assign wr_in_range = (32'(bus.wr_addr) < 32'(N_POINTS));
  assign rd_in_range = (32'(bus.rd_addr) < 32'(N_POINTS));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          idx_d   = FIRST_IDX;
          iter_d  = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!idx_is_last) begin
          idx_d   = idx_q + FIRST_IDX;
          state_d = S_ISSUE;
        end else if (iter_q != LAST_ITER) begin
          idx_d   = FIRST_IDX;
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    issue_en = 1'b0;
    wb_en    = 1'b0;
    host_wr  = 1'b0;
    unique case (state_q)
      S_IDLE:  host_wr  = bus.wr_en && wr_in_range;
      S_ISSUE: begin
        bus.busy = 1'b1;
        issue_en = 1'b1;
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        wb_en    = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Position file: host writes only in IDLE, engine writeback only in WAIT
  // ---------------------------------------------------------------------------
  // NOTE: this storage is cleared on reset because a mid-run abort must leave
  // no partially relaxed chain behind; plain storage would normally skip it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POINTS; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
      end
    end else if (host_wr) begin
      pos_x_q[bus.wr_addr] <= bus.wr_x;
      pos_y_q[bus.wr_addr] <= bus.wr_y;
    end else if (wb_en) begin
      pos_x_q[idx_q] <= bus.eng_x_res;
      pos_y_q[idx_q] <= bus.eng_y_res;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine operand registers: loaded in ISSUE, held otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_up_x_q    <= '0;
      eng_up_y_q    <= '0;
      eng_x_q       <= '0;
      eng_y_q       <= '0;
      eng_down_x_q  <= '0;
      eng_down_y_q  <= '0;
      eng_is_last_q <= 1'b0;
    end else if (issue_en) begin
      eng_up_x_q    <= pos_x_q[up_idx];
      eng_up_y_q    <= pos_y_q[up_idx];
      eng_x_q       <= pos_x_q[idx_q];
      eng_y_q       <= pos_y_q[idx_q];
      eng_down_x_q  <= pos_x_q[down_idx];
      eng_down_y_q  <= pos_y_q[down_idx];
      eng_is_last_q <= idx_is_last;
    end
  end

  assign bus.eng_up_x    = eng_up_x_q;
  assign bus.eng_up_y    = eng_up_y_q;
  assign bus.eng_x       = eng_x_q;
  assign bus.eng_y       = eng_y_q;
  assign bus.eng_down_x  = eng_down_x_q;
  assign bus.eng_down_y  = eng_down_y_q;
  assign bus.eng_is_last = eng_is_last_q;

  assign bus.rd_x = rd_in_range ? pos_x_q[bus.rd_addr] : '0;
  assign bus.rd_y = rd_in_range ? pos_y_q[bus.rd_addr] : '0;

endmodule
